ex_mem_wb_dest_track: RTL and testbench

- Write side of the EX-stage forwarding interface. Carries destination register number and write-enable of in-flight instructions through the EX/MEM and MEM/WB pipeline stages.
- Drives exmem_regRD/exmem_regWrite/memwb_regRD/memwb_regWrite, which the forwarding unit consumes to set ctrl_mux3/ctrl_mux4.
- Also owns the data-memory wait handshake, load-use stall detection and a stall-cycle counter.
- Sits between the ID/EX register and the writeback stage of the rv32 core.

---
 rtl/rv32_pkg.sv | 18 +
 rtl/ex_stall_ctr.sv | 26 ++
 rtl/ex_mem_wb_dest_track.sv | 135 +++++++++++++
 tb/tb_ex_mem_wb_dest_track.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the rv32 core pipeline blocks.
//   REG_ADDR_W : architectural register address width
//   REG_X0     : the hard-wired zero register, never a forwarding source
//   memState_t : data-memory handshake FSM states
// ---------------------------------------------------------------------------
package rv32_pkg;

  localparam int                    REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0     = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memState_t;

endpackage : rv32_pkg

// File: rtl/ex_stall_ctr.sv
// ---------------------------------------------------------------------------
// ex_stall_ctr
// Saturating up-counter with synchronous clear and increment enable.
//   clk   : clock
//   clr   : synchronous clear, wins over inc
//   inc   : add one this cycle unless already at all-ones
//   count : current count
// ---------------------------------------------------------------------------
module ex_stall_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule : ex_stall_ctr

// File: rtl/ex_mem_wb_dest_track.sv
// ---------------------------------------------------------------------------
// ex_mem_wb_dest_track
// Carries destination register / write-enable of in-flight instructions
// through EX/MEM and MEM/WB for the forwarding unit, runs the data-memory
// wait handshake, detects load-use hazards and counts front-end stall cycles.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   idex_*                   : instruction currently in ID/EX
//   ifid_regRS1/RS2          : sources of the instruction in IF/ID
//   flush                    : kill the instruction leaving ID/EX
//   dmem_ack / dmem_req      : data-memory completion / request
//   exmem_regRD/regWrite     : EX/MEM destination and qualified write-enable
//   memwb_regRD/regWrite     : MEM/WB destination and qualified write-enable
//   stall_front              : hold PC, IF/ID and ID/EX this cycle
//   stall_count              : saturating count of stall_front cycles
// ---------------------------------------------------------------------------
import rv32_pkg::*;

module ex_mem_wb_dest_track #(
  parameter int REG_W = REG_ADDR_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_valid,
  input  logic [REG_W-1:0] idex_regRD,
  input  logic             idex_regWrite,
  input  logic             idex_memRead,
  input  logic             idex_memWrite,
  input  logic [REG_W-1:0] ifid_regRS1,
  input  logic [REG_W-1:0] ifid_regRS2,
  input  logic             flush,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic [REG_W-1:0] exmem_regRD,
  output logic             exmem_regWrite,
  output logic [REG_W-1:0] memwb_regRD,
  output logic             memwb_regWrite,
  output logic             stall_front,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(REG_X0);

  memState_t state, stateNext;

  logic exmemValid;
  logic exmemMemRead;
  logic exmemMemWrite;
  logic killPending;

  logic loadUse;
  logic memStall;
  logic advance;
  logic captureValid;
  logic captureWrite;

  // Load in ID/EX whose destination is read by the instruction in IF/ID.
  assign loadUse = idex_valid & idex_memRead & idex_regWrite &
                   (idex_regRD != ZERO_REG) &
                   ((idex_regRD == ifid_regRS1) | (idex_regRD == ifid_regRS2));

  // NOTE: every signal written in always_comb gets a default first so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    stateNext = state;
    dmem_req  = 1'b0;
    unique case (state)
      IDLE: begin
        dmem_req = exmemValid & (exmemMemRead | exmemMemWrite);
        if (dmem_req && !dmem_ack) stateNext = WAIT;
      end
      WAIT: begin
        // EX/MEM is frozen, so the request is held until the ack arrives.
        dmem_req = 1'b1;
        if (dmem_ack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign memStall    = dmem_req & ~dmem_ack;
  assign advance     = ~memStall;
  assign stall_front = loadUse | memStall;

  // A load-use stall keeps the load in ID/EX and sends a bubble forward.
  assign captureValid = idex_valid & ~flush & ~killPending & ~loadUse;
  // x0 is never forwarded, nor is anything from a dead entry.
  assign captureWrite = captureValid & idex_regWrite & (idex_regRD != ZERO_REG);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      exmemValid     <= 1'b0;
      exmem_regRD    <= '0;
      exmem_regWrite <= 1'b0;
      exmemMemRead   <= 1'b0;
      exmemMemWrite  <= 1'b0;
      memwb_regRD    <= '0;
      memwb_regWrite <= 1'b0;
      killPending    <= 1'b0;
    end else begin
      state <= stateNext;
      if (advance) begin
        exmemValid     <= captureValid;
        exmem_regRD    <= idex_regRD;
        exmem_regWrite <= captureWrite;
        exmemMemRead   <= idex_memRead;
        exmemMemWrite  <= idex_memWrite;
        memwb_regRD    <= exmem_regRD;
        memwb_regWrite <= exmem_regWrite;
        // The capture just made consumed any pending kill.
        killPending    <= 1'b0;
      end else begin
        memwb_regRD    <= '0;
        memwb_regWrite <= 1'b0;
        // A flush seen while frozen must still kill what ID/EX sends next.
        if (flush) killPending <= 1'b1;
      end
    end
  end

  ex_stall_ctr #(
    .W (CNT_W)
  ) u_stall_ctr (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_front),
    .count (stall_count)
  );

endmodule : ex_mem_wb_dest_track

// File: tb/tb_ex_mem_wb_dest_track.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_wb_dest_track
// Two instances share all inputs: dut (16-bit stall counter) and satDut
// (2-bit stall counter, used for saturation). Directed scenarios use literal
// expectations; the random scenario uses a pipeline-slot reference model.
// ---------------------------------------------------------------------------
module tb_ex_mem_wb_dest_track;

  localparam int RW  = 5;
  localparam int CW  = 16;
  localparam int CWS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          idex_valid;
  logic [RW-1:0] idex_regRD;
  logic          idex_regWrite;
  logic          idex_memRead;
  logic          idex_memWrite;
  logic [RW-1:0] ifid_regRS1;
  logic [RW-1:0] ifid_regRS2;
  logic          flush;
  logic          dmem_ack;

  logic          dmem_req;
  logic [RW-1:0] exmem_regRD;
  logic          exmem_regWrite;
  logic [RW-1:0] memwb_regRD;
  logic          memwb_regWrite;
  logic          stall_front;
  logic [CW-1:0] stall_count;

  logic           satDmemReq;
  logic [RW-1:0]  satExmemRD;
  logic           satExmemWrite;
  logic [RW-1:0]  satMemwbRD;
  logic           satMemwbWrite;
  logic           satStallFront;
  logic [CWS-1:0] satStallCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_wb_dest_track #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .idex_valid(idex_valid), .idex_regRD(idex_regRD),
    .idex_regWrite(idex_regWrite), .idex_memRead(idex_memRead),
    .idex_memWrite(idex_memWrite), .ifid_regRS1(ifid_regRS1),
    .ifid_regRS2(ifid_regRS2), .flush(flush), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .exmem_regRD(exmem_regRD),
    .exmem_regWrite(exmem_regWrite), .memwb_regRD(memwb_regRD),
    .memwb_regWrite(memwb_regWrite), .stall_front(stall_front),
    .stall_count(stall_count)
  );

  ex_mem_wb_dest_track #(.REG_W(RW), .CNT_W(CWS)) satDut (
    .clk(clk), .rst(rst), .idex_valid(idex_valid), .idex_regRD(idex_regRD),
    .idex_regWrite(idex_regWrite), .idex_memRead(idex_memRead),
    .idex_memWrite(idex_memWrite), .ifid_regRS1(ifid_regRS1),
    .ifid_regRS2(ifid_regRS2), .flush(flush), .dmem_ack(dmem_ack),
    .dmem_req(satDmemReq), .exmem_regRD(satExmemRD),
    .exmem_regWrite(satExmemWrite), .memwb_regRD(satMemwbRD),
    .memwb_regWrite(satMemwbWrite), .stall_front(satStallFront),
    .stall_count(satStallCount)
  );

  // Step to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle;
    idex_valid    = 1'b0;
    idex_regRD    = '0;
    idex_regWrite = 1'b0;
    idex_memRead  = 1'b0;
    idex_memWrite = 1'b0;
    ifid_regRS1   = '0;
    ifid_regRS2   = '0;
    flush         = 1'b0;
    dmem_ack      = 1'b0;
  endtask

  task automatic setIdex(input logic [RW-1:0] rd, input logic we,
                         input logic mr, input logic mw);
    idex_valid    = 1'b1;
    idex_regRD    = rd;
    idex_regWrite = we;
    idex_memRead  = mr;
    idex_memWrite = mw;
  endtask

  task automatic doReset;
    rst = 1'b1;
    setIdle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    // Hostile inputs during reset: rst must still win.
    rst = 1'b1;
    setIdex(5'd7, 1'b1, 1'b1, 1'b0);
    ifid_regRS1 = 5'd7;
    flush = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    setIdle();
    #1;
    checks++;
    if ({dmem_req, exmem_regRD, exmem_regWrite, memwb_regRD, memwb_regWrite, stall_front} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b exRD=%0d exWE=%b wbRD=%0d wbWE=%b stall=%b want all 0",
               dmem_req, exmem_regRD, exmem_regWrite, memwb_regRD, memwb_regWrite, stall_front);
    end
    checks++;
    if (stall_count !== '0 || satStallCount !== '0) begin
      errors++;
      $display("FAIL reset_count got %0d/%0d want 0/0", stall_count, satStallCount);
    end
  endtask

  task automatic test_back_to_back;
    doReset();
    setIdex(5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    setIdex(5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (exmem_regRD !== 5'd5 || exmem_regWrite !== 1'b1) begin
      errors++;
      $display("FAIL b2b_cycle1_exmem got rd=%0d we=%b want rd=5 we=1", exmem_regRD, exmem_regWrite);
    end
    tick();
    setIdle();
    #1;
    checks++;
    if (exmem_regRD !== 5'd6 || exmem_regWrite !== 1'b1) begin
      errors++;
      $display("FAIL b2b_cycle2_exmem got rd=%0d we=%b want rd=6 we=1", exmem_regRD, exmem_regWrite);
    end
    checks++;
    if (memwb_regRD !== 5'd5 || memwb_regWrite !== 1'b1) begin
      errors++;
      $display("FAIL b2b_cycle2_memwb got rd=%0d we=%b want rd=5 we=1", memwb_regRD, memwb_regWrite);
    end
    checks++;
    if (stall_front !== 1'b0 || stall_count !== '0) begin
      errors++;
      $display("FAIL b2b_no_stall got stall=%b count=%0d want 0 0", stall_front, stall_count);
    end
  endtask

  task automatic test_x0;
    doReset();
    setIdex(5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    setIdle();
    #1;
    checks++;
    if (exmem_regWrite !== 1'b0) begin
      errors++;
      $display("FAIL x0_exmem_we got %b want 0", exmem_regWrite);
    end
    tick();
    checks++;
    if (memwb_regWrite !== 1'b0) begin
      errors++;
      $display("FAIL x0_memwb_we got %b want 0", memwb_regWrite);
    end
  endtask

  task automatic test_load_use;
    doReset();
    setIdex(5'd7, 1'b1, 1'b1, 1'b0);
    ifid_regRS1 = 5'd3;
    ifid_regRS2 = 5'd7;
    #1;
    checks++;
    if (stall_front !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got %b want 1", stall_front);
    end
    tick();
    ifid_regRS2 = 5'd0;
    #1;
    checks++;
    if (exmem_regWrite !== 1'b0 || dmem_req !== 1'b0 || stall_front !== 1'b0) begin
      errors++;
      $display("FAIL lu_bubble got exWE=%b req=%b stall=%b want 0 0 0", exmem_regWrite, dmem_req, stall_front);
    end
    checks++;
    if (stall_count !== 16'd1) begin
      errors++;
      $display("FAIL lu_count got %0d want 1", stall_count);
    end
    tick();
    setIdle();
    dmem_ack = 1'b1;
    #1;
    checks++;
    if (exmem_regRD !== 5'd7 || exmem_regWrite !== 1'b1 || dmem_req !== 1'b1 || stall_front !== 1'b0) begin
      errors++;
      $display("FAIL lu_load_issue got rd=%0d we=%b req=%b stall=%b want 7 1 1 0",
               exmem_regRD, exmem_regWrite, dmem_req, stall_front);
    end
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (memwb_regRD !== 5'd7 || memwb_regWrite !== 1'b1 || stall_count !== 16'd1) begin
      errors++;
      $display("FAIL lu_retire got rd=%0d we=%b count=%0d want 7 1 1", memwb_regRD, memwb_regWrite, stall_count);
    end
  endtask

  task automatic test_mem_wait;
    int reqCycles;
    int stallCycles;
    reqCycles = 0;
    stallCycles = 0;
    doReset();
    setIdex(5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    setIdle();
    for (int c = 0; c < 4; c++) begin
      dmem_ack = (c == 3);
      #1;
      if (dmem_req) reqCycles++;
      if (stall_front) stallCycles++;
      checks++;
      if (exmem_regRD !== 5'd9 || exmem_regWrite !== 1'b1) begin
        errors++;
        $display("FAIL wait_exmem_hold c=%0d got rd=%0d we=%b want 9 1", c, exmem_regRD, exmem_regWrite);
      end
      if (c > 0) begin
        checks++;
        if (memwb_regWrite !== 1'b0 || memwb_regRD !== 5'd0) begin
          errors++;
          $display("FAIL wait_memwb_bubble c=%0d got rd=%0d we=%b want 0 0", c, memwb_regRD, memwb_regWrite);
        end
      end
      tick();
    end
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (reqCycles != 4 || stallCycles != 3) begin
      errors++;
      $display("FAIL wait_cycles got req=%0d stall=%0d want 4 3", reqCycles, stallCycles);
    end
    checks++;
    if (memwb_regRD !== 5'd9 || memwb_regWrite !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL wait_advance got rd=%0d we=%b req=%b want 9 1 0", memwb_regRD, memwb_regWrite, dmem_req);
    end
    checks++;
    if (stall_count !== 16'd3) begin
      errors++;
      $display("FAIL wait_count got %0d want 3", stall_count);
    end
  endtask

  task automatic test_flush_wait;
    doReset();
    setIdex(5'd10, 1'b1, 1'b1, 1'b0);
    tick();
    setIdex(5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dmem_ack = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || stall_front !== 1'b0) begin
      errors++;
      $display("FAIL flush_ack_cycle got req=%b stall=%b want 1 0", dmem_req, stall_front);
    end
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (memwb_regRD !== 5'd10 || memwb_regWrite !== 1'b1) begin
      errors++;
      $display("FAIL flush_load_retires got rd=%0d we=%b want 10 1", memwb_regRD, memwb_regWrite);
    end
    checks++;
    if (exmem_regWrite !== 1'b0) begin
      errors++;
      $display("FAIL flush_killed got we=%b want 0", exmem_regWrite);
    end
    tick();
    checks++;
    if (exmem_regRD !== 5'd11 || exmem_regWrite !== 1'b1) begin
      errors++;
      $display("FAIL flush_kill_clears got rd=%0d we=%b want 11 1", exmem_regRD, exmem_regWrite);
    end
  endtask

  task automatic test_saturation_reset;
    doReset();
    setIdex(5'd12, 1'b1, 1'b1, 1'b0);
    tick();
    setIdle();
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (satStallCount !== 2'd3 || stall_count !== 16'd5) begin
      errors++;
      $display("FAIL sat_count got sat=%0d wide=%0d want 3 5", satStallCount, stall_count);
    end
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL sat_still_waiting got req=%b want 1", dmem_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({dmem_req, exmem_regRD, exmem_regWrite, memwb_regRD, memwb_regWrite, stall_front} !== '0 ||
        stall_count !== '0 || satStallCount !== '0) begin
      errors++;
      $display("FAIL rst_mid_wait got req=%b exRD=%0d exWE=%b wbRD=%0d wbWE=%b stall=%b cnt=%0d want all 0",
               dmem_req, exmem_regRD, exmem_regWrite, memwb_regRD, memwb_regWrite, stall_front, stall_count);
    end
    tick();
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_abandons_access got req=%b want 0", dmem_req);
    end
  endtask

  // Reference model: one slot per pipeline register, holding the raw fields
  // of the instruction it carries; qualification is applied on read.
  typedef struct packed {
    bit          valid;
    bit [RW-1:0] rd;
    bit          we;
    bit          mr;
    bit          mw;
  } slot_t;

  task automatic test_random;
    slot_t       mEx;
    bit [RW-1:0] mWbRd;
    bit          mWbWe;
    bit          mKill;
    int          mCount;
    bit          eReq, eMemStall, eLoadUse, eFront, eExWe;
    int          eSat;
    doReset();
    mEx    = '0;
    mWbRd  = '0;
    mWbWe  = 1'b0;
    mKill  = 1'b0;
    mCount = 0;
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 63) == 0);
      idex_valid    = ($urandom_range(0, 3) != 0);
      idex_regRD    = RW'($urandom_range(0, 7));
      idex_regWrite = $urandom_range(0, 3) != 0;
      idex_memRead  = ($urandom_range(0, 2) == 0);
      idex_memWrite = !idex_memRead && ($urandom_range(0, 3) == 0);
      ifid_regRS1   = RW'($urandom_range(0, 7));
      ifid_regRS2   = RW'($urandom_range(0, 7));
      flush         = ($urandom_range(0, 7) == 0);
      dmem_ack      = ($urandom_range(0, 1) == 1);
      #1;
      eReq      = mEx.valid && (mEx.mr || mEx.mw);
      eMemStall = eReq && !dmem_ack;
      eLoadUse  = idex_valid && idex_memRead && idex_regWrite && (idex_regRD != 0) &&
                  ((idex_regRD == ifid_regRS1) || (idex_regRD == ifid_regRS2));
      eFront    = eLoadUse || eMemStall;
      eExWe     = mEx.valid && mEx.we && (mEx.rd != 0);
      eSat      = (mCount > 3) ? 3 : mCount;
      checks++;
      if (dmem_req !== eReq || stall_front !== eFront) begin
        errors++;
        $display("FAIL rand_ctrl n=%0d got req=%b stall=%b want %b %b", n, dmem_req, stall_front, eReq, eFront);
      end
      checks++;
      if (exmem_regRD !== mEx.rd || exmem_regWrite !== eExWe) begin
        errors++;
        $display("FAIL rand_exmem n=%0d got rd=%0d we=%b want %0d %b", n, exmem_regRD, exmem_regWrite, mEx.rd, eExWe);
      end
      checks++;
      if (memwb_regRD !== mWbRd || memwb_regWrite !== mWbWe) begin
        errors++;
        $display("FAIL rand_memwb n=%0d got rd=%0d we=%b want %0d %b", n, memwb_regRD, memwb_regWrite, mWbRd, mWbWe);
      end
      checks++;
      if (stall_count !== CW'(mCount) || satStallCount !== CWS'(eSat)) begin
        errors++;
        $display("FAIL rand_count n=%0d got %0d/%0d want %0d/%0d", n, stall_count, satStallCount, mCount, eSat);
      end
      if (rst) begin
        mEx    = '0;
        mWbRd  = '0;
        mWbWe  = 1'b0;
        mKill  = 1'b0;
        mCount = 0;
      end else begin
        if (!eMemStall) begin
          mWbRd = mEx.rd;
          mWbWe = eExWe;
          mEx   = '{valid: idex_valid && !flush && !mKill && !eLoadUse, rd: idex_regRD,
                    we: idex_regWrite, mr: idex_memRead, mw: idex_memWrite};
          mKill = 1'b0;
        end else begin
          mWbRd = '0;
          mWbWe = 1'b0;
          mKill = mKill || flush;
        end
        if (eFront && mCount < 65535) mCount++;
      end
      tick();
    end
    rst = 1'b0;
    setIdle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    setIdle();
    #1;
    test_reset();
    test_back_to_back();
    test_x0();
    test_load_use();
    test_mem_wait();
    test_flush_wait();
    test_saturation_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ex_mem_wb_dest_track
